// File: rtl/simd_mult_pkg.sv
// simd_mult_pkg
// Shared definitions for the SIMD multiplier scheduler: precision-mode encodings
// and per-lane product widths used by the lane multiplier and the top level.
package simd_mult_pkg;

    localparam int unsigned MODE_BITS = 2;

    localparam logic [MODE_BITS-1:0] MODE_INT8 = 2'b00;
    localparam logic [MODE_BITS-1:0] MODE_INT4 = 2'b01;
    localparam logic [MODE_BITS-1:0] MODE_INT2 = 2'b10;
    localparam logic [MODE_BITS-1:0] MODE_RSVD = 2'b11;

    // Product width per lane for each precision.
    localparam int unsigned LANE_W_INT2 = 4;
    localparam int unsigned LANE_W_INT4 = 8;
    localparam int unsigned LANE_W_INT8 = 16;

endpackage

// File: rtl/simd_mul8_lanes.sv
// simd_mul8_lanes
// Combinational 8-bit precision-configurable unsigned multiplier. All modes are
// assembled from the sixteen 2-bit x 2-bit partial products of a and b.
// Ports:
//   a, b      : 8-bit operands
//   mode      : 00=INT8, 01=2xINT4, 10=4xINT2, 11=reserved (computed as INT8)
//   out_data  : packed 16-bit product
//   err       : reserved mode requested
module simd_mul8_lanes
    import simd_mult_pkg::*;
(
    input  logic [7:0]           a,
    input  logic [7:0]           b,
    input  logic [MODE_BITS-1:0] mode,
    output logic [15:0]          out_data,
    output logic                 err
);

    // pp[i][j] = a digit i times b digit j (2-bit digits, 4-bit product)
    logic [LANE_W_INT2-1:0] pp [4][4];
    logic [LANE_W_INT8-1:0] p8;
    logic [LANE_W_INT4-1:0] p4 [2];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                pp[i][j] = {2'b00, a[2*i +: 2]} * {2'b00, b[2*j +: 2]};
            end
        end
    end

    // Full 8x8: digit (i, j) carries weight 4^(i+j).
    always_comb begin
        p8 = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                p8 = p8 + (LANE_W_INT8'(pp[i][j]) << (2 * (i + j)));
            end
        end
    end

    // Each 4x4 lane k uses only the digits inside nibble k of both operands.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            p4[k] = '0;
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 2; j++) begin
                    p4[k] = p4[k] + (LANE_W_INT4'(pp[2*k+i][2*k+j]) << (2 * (i + j)));
                end
            end
        end
    end

    always_comb begin
        case (mode)
            MODE_INT4: out_data = {p4[1], p4[0]};
            MODE_INT2: out_data = {pp[3][3], pp[2][2], pp[1][1], pp[0][0]};
            default:   out_data = p8;
        endcase
        err = (mode == MODE_RSVD);
    end

endmodule

// File: rtl/simd_mult_scheduler.sv
// simd_mult_scheduler
// Shares one SIMD multiplier between two requesters. A round-robin arbiter picks
// a requester, stage S1 registers its operands, stage S2 registers the packed
// product; outputs come straight from S2 under valid/ready backpressure.
// Ports:
//   clk, rst                    : clock, async active-high reset
//   reqN_valid/ready/a/b/mode   : requester N operand handshake (N = 0, 1)
//   out_valid/ready             : product handshake
//   out_data/id/mode/err        : packed product, issuing requester, mode, reserved flag
//   busy                        : S1 or S2 holds a valid entry
module simd_mult_scheduler
    import simd_mult_pkg::*;
#(
    parameter int unsigned RESET_PRIO = 0,
    parameter int unsigned MODE_W     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [7:0]        req0_a,
    input  logic [7:0]        req0_b,
    input  logic [MODE_W-1:0] req0_mode,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [7:0]        req1_a,
    input  logic [7:0]        req1_b,
    input  logic [MODE_W-1:0] req1_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_data,
    output logic              out_id,
    output logic [MODE_W-1:0] out_mode,
    output logic              out_err,
    output logic              busy
);

    // Arbiter state: requester of the most recent accepted transfer.
    logic last_grant;
    logic grant;
    logic accept;

    // Stage S1 (issue)
    logic              s1_valid;
    logic              s1_id;
    logic [7:0]        s1_a;
    logic [7:0]        s1_b;
    logic [MODE_W-1:0] s1_mode;

    logic s1_load;
    logic s2_load;
    logic s1_adv;

    logic [15:0] mul_data;
    logic        mul_err;

    always_comb begin
        // Contested: the one not granted last wins. Otherwise the lone valid one.
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = req1_valid;
        end

        s2_load = !out_valid || out_ready;
        s1_adv  = s1_valid && s2_load;
        s1_load = !s1_valid || s1_adv;
        accept  = (req0_valid || req1_valid) && s1_load && !rst;

        req0_ready = accept && !grant;
        req1_ready = accept && grant;
        busy       = s1_valid || out_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= (RESET_PRIO == 0);
        end else if (accept) begin
            last_grant <= grant;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_id    <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_mode  <= '0;
        end else if (s1_load) begin
            s1_valid <= accept;
            if (accept) begin
                s1_id   <= grant;
                s1_a    <= grant ? req1_a : req0_a;
                s1_b    <= grant ? req1_b : req0_b;
                s1_mode <= grant ? req1_mode : req0_mode;
            end
        end
    end

    simd_mul8_lanes u_lanes (
        .a        (s1_a),
        .b        (s1_b),
        .mode     (s1_mode),
        .out_data (mul_data),
        .err      (mul_err)
    );

    // Stage S2 (result); payload only changes when a valid entry moves in,
    // so it holds while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= 1'b0;
            out_mode  <= '0;
            out_err   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= mul_data;
                out_id   <= s1_id;
                out_mode <= s1_mode;
                out_err  <= mul_err;
            end
        end
    end

endmodule

// File: tb/tb_simd_mult_scheduler.sv
// tb_simd_mult_scheduler
// Self-checking bench: accepted transfers are pushed to a scoreboard with a
// reference product; every consumed output is popped and compared.
module tb_simd_mult_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [7:0]  req0_a, req0_b;
    logic [1:0]  req0_mode;
    logic        req1_valid, req1_ready;
    logic [7:0]  req1_a, req1_b;
    logic [1:0]  req1_mode;
    logic        out_valid, out_ready;
    logic [15:0] out_data;
    logic        out_id;
    logic [1:0]  out_mode;
    logic        out_err;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_acc    = 0;

    logic [19:0] sb_q [$];   // {id, mode, err, data}
    logic        acc_q [$];  // id of each accepted transfer
    logic [19:0] sb_exp;

    always #5 clk = ~clk;

    simd_mult_scheduler #(.RESET_PRIO(0), .MODE_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_mode  (req0_mode),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_mode  (req1_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_mode   (out_mode),
        .out_err    (out_err),
        .busy       (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [19:0] model(input logic id, input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] mode);
        logic [15:0] d;
        case (mode)
            2'b01:   d = {8'(8'(a[7:4]) * 8'(b[7:4])), 8'(8'(a[3:0]) * 8'(b[3:0]))};
            2'b10:   d = {4'(4'(a[7:6]) * 4'(b[7:6])), 4'(4'(a[5:4]) * 4'(b[5:4])),
                          4'(4'(a[3:2]) * 4'(b[3:2])), 4'(4'(a[1:0]) * 4'(b[1:0]))};
            default: d = 16'(a) * 16'(b);
        endcase
        return {id, mode, (mode == 2'b11), d};
    endfunction

    // Scoreboard monitor, mid-cycle so inputs and outputs are settled.
    always @(negedge clk) begin
        if (!rst) begin
            if (req0_valid && req1_valid) begin
                check_eq("one_ready", 32'(req0_ready && req1_ready), 32'd0);
            end
            if (req0_valid && req0_ready) begin
                sb_q.push_back(model(1'b0, req0_a, req0_b, req0_mode));
                acc_q.push_back(1'b0);
                n_acc++;
            end
            if (req1_valid && req1_ready) begin
                sb_q.push_back(model(1'b1, req1_a, req1_b, req1_mode));
                acc_q.push_back(1'b1);
                n_acc++;
            end
            if (out_valid && out_ready) begin
                check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    sb_exp = sb_q.pop_front();
                    check_eq("sb_data", 32'({out_id, out_mode, out_err, out_data}), 32'(sb_exp));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic id, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] m);
        bit done = 0;
        if (id) begin
            req1_valid = 1; req1_a = a; req1_b = b; req1_mode = m;
        end else begin
            req0_valid = 1; req0_a = a; req0_b = b; req0_mode = m;
        end
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            done = id ? req1_ready : req0_ready;
            tick();
        end
        check_eq("send_hs", 32'(done), 32'd1);
        if (id) req1_valid = 0;
        else    req0_valid = 0;
    endtask

    task automatic rand_req(input logic id);
        if (id) begin
            req1_a = 8'($urandom); req1_b = 8'($urandom); req1_mode = 2'($urandom_range(0, 3));
        end else begin
            req0_a = 8'($urandom); req0_b = 8'($urandom); req0_mode = 2'($urandom_range(0, 3));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r0, r1;
        int          gaps, acc0, stale;
        logic [15:0] held;

        rst = 1; out_ready = 0;
        req0_valid = 1; req0_a = 0; req0_b = 0; req0_mode = 0;
        req1_valid = 1; req1_a = 0; req1_b = 0; req1_mode = 0;
        tick(); tick();
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ready0", 32'(req0_ready), 32'd0);
        check_eq("rst_ready1", 32'(req1_ready), 32'd0);
        check_eq("rst_out_pkt", 32'({out_id, out_mode, out_err, out_data}), 32'd0);
        req0_valid = 0; req1_valid = 0;
        rst = 0; out_ready = 1;
        tick();

        // INT8 with latency check
        send(1'b0, 8'hFF, 8'hFF, 2'b00);
        check_eq("lat_edge1", 32'(out_valid), 32'd0);
        tick();
        check_eq("lat_edge2", 32'(out_valid), 32'd1);
        check_eq("int8_data", 32'(out_data), 32'hFE01);
        check_eq("int8_id", 32'(out_id), 32'd0);
        check_eq("int8_err", 32'(out_err), 32'd0);

        send(1'b1, 8'h37, 8'h25, 2'b01);
        tick();
        check_eq("int4_data", 32'(out_data), 32'h0623);
        check_eq("int4_id", 32'(out_id), 32'd1);

        send(1'b0, 8'hE7, 8'hF9, 2'b10);
        tick();
        check_eq("int2_data", 32'(out_data), 32'h9623);
        tick(); tick();

        // Contention from reset: grants must alternate 0,1,0,1,...
        rst = 1; tick(); rst = 0;
        acc_q.delete();
        rand_req(1'b0); rand_req(1'b1);
        req0_valid = 1; req1_valid = 1;
        gaps = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            r0 = req0_ready; r1 = req1_ready;
            if (i >= 2 && !out_valid) gaps++;
            tick();
            if (r0) rand_req(1'b0);
            if (r1) rand_req(1'b1);
        end
        req0_valid = 0; req1_valid = 0;
        check_eq("cont_gaps", 32'(gaps), 32'd0);
        check_eq("cont_count", 32'(acc_q.size()), 32'd10);
        for (int i = 0; i < acc_q.size(); i++) begin
            check_eq($sformatf("cont_grant%0d", i), 32'(acc_q[i]), 32'(i % 2));
        end
        repeat (4) tick();
        check_eq("cont_drain", 32'(sb_q.size()), 32'd0);

        // Backpressure: only S1 and S2 can fill
        out_ready = 0;
        rand_req(1'b0); rand_req(1'b1);
        req0_valid = 1; req1_valid = 1;
        acc0 = n_acc;
        held = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 2) held = out_data;
        end
        check_eq("bp_accepts", 32'(n_acc - acc0), 32'd2);
        check_eq("bp_ready0", 32'(req0_ready), 32'd0);
        check_eq("bp_ready1", 32'(req1_ready), 32'd0);
        check_eq("bp_valid", 32'(out_valid), 32'd1);
        check_eq("bp_stable", 32'(out_data), 32'(held));
        req0_valid = 0; req1_valid = 0;
        out_ready = 1;
        repeat (4) tick();
        check_eq("bp_drain", 32'(sb_q.size()), 32'd0);
        check_eq("bp_idle", 32'(busy), 32'd0);

        // Reserved mode
        send(1'b1, 8'h10, 8'h10, 2'b11);
        tick();
        check_eq("rsvd_data", 32'(out_data), 32'h0100);
        check_eq("rsvd_err", 32'(out_err), 32'd1);
        check_eq("rsvd_mode", 32'(out_mode), 32'd3);
        tick();

        // Reset with two entries in flight
        out_ready = 0;
        rand_req(1'b0); rand_req(1'b1);
        req0_valid = 1; req1_valid = 1;
        tick(); tick();
        check_eq("flight_busy", 32'(busy), 32'd1);
        rst = 1;
        #1;
        check_eq("flight_rst_valid", 32'(out_valid), 32'd0);
        check_eq("flight_rst_busy", 32'(busy), 32'd0);
        sb_q.delete();
        req0_valid = 0; req1_valid = 0;
        tick();
        rst = 0; out_ready = 1;
        stale = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid) stale++;
        end
        check_eq("flight_no_stale", 32'(stale), 32'd0);
        check_eq("final_drain", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
